// File: rtl/sum_io_rd_pkg.sv
// Shared types and helpers for the sum_io RAM block reader.
package sum_io_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    localparam int FIFO_DEPTH = 2;

    // Operands arrive zero-extended, so start+len and base+span cannot wrap.
    function automatic logic range_ok(input logic [31:0] start,
                                      input logic [31:0] count,
                                      input logic [31:0] base,
                                      input logic [31:0] span);
        return (start >= base) && ((start + count) <= (base + span));
    endfunction

endpackage

// File: rtl/sum_io_rd_fifo2.sv
// Two-entry register FIFO; e0 is always the head so dout needs no read mux.
module sum_io_rd_fifo2 #(
    parameter int DataWidth = 400
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] din,
    output logic [DataWidth-1:0] dout,
    output logic [1:0]           count
);

    logic [DataWidth-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]           cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = din;
                else               e1_d = din;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop keeps the count; the new word lands behind the survivor.
                if (cnt_q == 2'd1) begin
                    e0_d = din;
                end else begin
                    e0_d = e1_q;
                    e1_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = e0_q;
    assign count = cnt_q;

endmodule

// File: rtl/sum_io_mem_reader.sv
// Reads a contiguous block from the sum_io RAM and streams it out with backpressure.
// Optional rd_csum output (XOR of transferred beats) under SUM_IO_RD_CHECKSUM_EN.
module sum_io_mem_reader
    import sum_io_rd_pkg::*;
#(
    parameter int DataWidth    = 400,
    parameter int AddressWidth = 13,
    parameter int BaseAddr     = 4000,
    parameter int AddressRange = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic [AddressWidth-1:0] start_addr,
    input  logic [AddressWidth-1:0] len,
    output logic                    ap_idle,
    output logic                    ap_done,
    output logic                    ap_err,
    output logic [AddressWidth-1:0] address0,
    output logic                    ce0,
    input  logic [DataWidth-1:0]    q0,
    output logic [DataWidth-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last
`ifdef SUM_IO_RD_CHECKSUM_EN
    ,
    output logic [DataWidth-1:0]    rd_csum
`endif
);

    rd_state_e               state_q, state_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [AddressWidth-1:0] len_q, len_d;
    logic [AddressWidth-1:0] issue_q, issue_d;
    logic [AddressWidth-1:0] out_q, out_d;
    logic                    err_q, err_d;
    logic                    inflight_q;
    logic [DataWidth-1:0]    fifo_head;
    logic [1:0]              fifo_cnt;
    logic [1:0]              occ_after;
    logic                    xfer;
    logic                    ok;

    sum_io_rd_fifo2 #(.DataWidth(DataWidth)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .pop   (xfer),
        .din   (q0),
        .dout  (fifo_head),
        .count (fifo_cnt)
    );

    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = fifo_head;
    assign xfer    = m_valid && m_ready;
    assign m_last  = m_valid && (out_q == (len_q - AddressWidth'(1)));

    // Occupancy counts the pop happening this cycle so a full-rate stream can keep issuing.
    assign occ_after = fifo_cnt - 2'(xfer) + 2'(inflight_q);
    assign ce0       = (state_q == ST_RUN) && (issue_q != len_q)
                       && (occ_after < 2'(FIFO_DEPTH));
    assign address0  = (state_q == ST_RUN) ? (addr_q + issue_q) : '0;

    assign ok = range_ok(32'(start_addr), 32'(len), 32'(BaseAddr), 32'(AddressRange));

    assign ap_idle = (state_q == ST_IDLE);
    assign ap_done = (state_q == ST_DONE);
    assign ap_err  = ap_done && err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        issue_d = issue_q;
        out_d   = out_q + AddressWidth'(xfer);
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    addr_d  = start_addr;
                    len_d   = len;
                    issue_d = '0;
                    out_d   = '0;
                    err_d   = !ok;
                    state_d = (!ok || (len == '0)) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (ce0) issue_d = issue_q + AddressWidth'(1);
                if (issue_d == len_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Finish on the cycle of the final transfer so ap_done follows it directly.
                if ((out_d == len_q) && !inflight_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issue_q    <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issue_q    <= issue_d;
            out_q      <= out_d;
            err_q      <= err_d;
            inflight_q <= ce0;
        end
    end

`ifdef SUM_IO_RD_CHECKSUM_EN
    logic [DataWidth-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == ST_IDLE) && ap_start) csum_d = '0;
        else if (xfer)                        csum_d = csum_q ^ fifo_head;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign rd_csum = csum_q;
`endif

endmodule

// File: tb/tb_sum_io_mem_reader.sv
// Directed bench for sum_io_mem_reader: vector table of jobs plus reset and back-to-back sequences.
module tb_sum_io_mem_reader;

    localparam int DW   = 400;
    localparam int AW   = 13;
    localparam int BASE = 4000;
    localparam int SPAN = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          ap_start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] len;
    logic          ap_idle, ap_done, ap_err;
    logic [AW-1:0] address0;
    logic          ce0;
    logic [DW-1:0] q0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
`ifdef SUM_IO_RD_CHECKSUM_EN
    logic [DW-1:0] rd_csum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sum_io_mem_reader #(
        .DataWidth(DW), .AddressWidth(AW), .BaseAddr(BASE), .AddressRange(SPAN)
    ) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .start_addr(start_addr), .len(len),
        .ap_idle(ap_idle), .ap_done(ap_done), .ap_err(ap_err),
        .address0(address0), .ce0(ce0), .q0(q0),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
`ifdef SUM_IO_RD_CHECKSUM_EN
        , .rd_csum(rd_csum)
`endif
    );

    // RAM model: word i holds i+1, one-cycle read latency.
    logic [DW-1:0] mem [0:SPAN-1];
    int            ram_idx;
    always @(posedge clk) begin
        if (ce0) begin
            ram_idx = int'(address0) - BASE;
            if (ram_idx >= 0 && ram_idx < SPAN) q0 <= mem[ram_idx];
            else                                q0 <= '0;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW-1:0] ln;
        int            mode;     // 0: m_ready always 1, 1: ready pattern 1,0,0,1
        bit            exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic run_job(input vec_t v);
        int            nb = 0, issued = 0, cyc = 0, xf;
        int            first_cyc = -1, last_cyc = -1, done_cyc = -1;
        int            exp_beats;
        bit            stalled = 0, got_done = 0;
        logic          done_err = 1'b0;
        logic [DW-1:0] prev_d = '0, exp_x = '0, csum_at_done = '0;
        logic          prev_l = 1'b0;
        exp_beats = v.exp_err ? 0 : int'(v.ln);
        @(negedge clk);
        ap_start = 1'b1; start_addr = v.sa; len = v.ln;
        while (!got_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            ap_start = 1'b0;
            m_ready = (v.mode == 0) ? 1'b1 : (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
            #1;
            xf = (m_valid && m_ready) ? 1 : 0;
            if (ap_err && !ap_done) chk("err_without_done", DW'(ap_err), '0);
            if (ce0) begin
                chk("issue_limit", DW'((issued - nb - xf) < 2), DW'(1));
                issued++;
            end
            if (stalled) begin
                chk("hold_valid", DW'(m_valid), DW'(1));
                chk("hold_data", m_data, prev_d);
                chk("hold_last", DW'(m_last), DW'(prev_l));
            end
            stalled = 0;
            if (m_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (m_ready) begin
                    chk("beat_data", m_data, DW'(int'(v.sa) - BASE + nb + 1));
                    chk("beat_last", DW'(m_last), DW'(nb == int'(v.ln) - 1));
                    exp_x = exp_x ^ DW'(int'(v.sa) - BASE + nb + 1);
                    nb++;
                    last_cyc = cyc;
                end else begin
                    stalled = 1;
                    prev_d  = m_data;
                    prev_l  = m_last;
                end
            end
            if (ap_done) begin
                got_done = 1;
                done_cyc = cyc;
                done_err = ap_err;
`ifdef SUM_IO_RD_CHECKSUM_EN
                csum_at_done = rd_csum;
`endif
            end
        end
        m_ready = 1'b1;
        chk("done_seen", DW'(got_done), DW'(1));
        chk("done_err", DW'(done_err), DW'(v.exp_err));
        chk("beat_count", DW'(nb), DW'(exp_beats));
        chk("read_count", DW'(issued), DW'(exp_beats));
        if (exp_beats > 0) begin
            chk("done_after_last", DW'(done_cyc), DW'(last_cyc + 1));
            if (v.mode == 0) begin
                chk("first_beat_lat", DW'(first_cyc), DW'(3));
                chk("full_rate", DW'(last_cyc - first_cyc), DW'(exp_beats - 1));
            end
        end else begin
            chk("quick_done", DW'(done_cyc <= 2), DW'(1));
        end
`ifdef SUM_IO_RD_CHECKSUM_EN
        chk("csum", csum_at_done, exp_x);
`else
        if (csum_at_done != '0) chk("csum_absent", csum_at_done, '0);
`endif
    endtask

    task automatic check_reset_outputs();
        chk("rst_idle", DW'(ap_idle), DW'(1));
        chk("rst_done", DW'(ap_done), '0);
        chk("rst_err", DW'(ap_err), '0);
        chk("rst_ce0", DW'(ce0), '0);
        chk("rst_addr", DW'(address0), '0);
        chk("rst_valid", DW'(m_valid), '0);
        chk("rst_last", DW'(m_last), '0);
        chk("rst_data", m_data, '0);
`ifdef SUM_IO_RD_CHECKSUM_EN
        chk("rst_csum", rd_csum, '0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int guard;
        bit seen;
        for (int i = 0; i < SPAN; i++) mem[i] = DW'(i + 1);
        q0 = '0;
        vecs[0] = '{sa: 13'd4000, ln: 13'd8,  mode: 0, exp_err: 1'b0};
        vecs[1] = '{sa: 13'd4000, ln: 13'd8,  mode: 1, exp_err: 1'b0};
        vecs[2] = '{sa: 13'd4995, ln: 13'd10, mode: 0, exp_err: 1'b1};
        vecs[3] = '{sa: 13'd3999, ln: 13'd1,  mode: 0, exp_err: 1'b1};
        vecs[4] = '{sa: 13'd4500, ln: 13'd0,  mode: 0, exp_err: 1'b0};
        vecs[5] = '{sa: 13'd4990, ln: 13'd10, mode: 1, exp_err: 1'b0};
        vecs[6] = '{sa: 13'd4999, ln: 13'd1,  mode: 0, exp_err: 1'b0};

        reset = 1'b0; ap_start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b1;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 7; k++) run_job(vecs[k]);

        // Reset in the middle of a job: outputs clear at once and no ap_done follows.
        @(negedge clk);
        ap_start = 1'b1; start_addr = 13'd4000; len = 13'd8; m_ready = 1'b1;
        nb = 0; guard = 0;
        while (nb < 3 && guard < 50) begin
            @(negedge clk);
            ap_start = 1'b0;
            #1;
            if (m_valid && m_ready) nb++;
            guard++;
        end
        chk("pre_reset_beats", DW'(nb), DW'(3));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("no_done_in_reset", DW'(ap_done), '0);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("no_done_after_reset", DW'(ap_done), '0);
        run_job('{sa: 13'd4002, ln: 13'd2, mode: 0, exp_err: 1'b0});

        // ap_start held high: one IDLE cycle after ap_done, then straight back to RUN.
        @(negedge clk);
        ap_start = 1'b1; start_addr = 13'd4000; len = 13'd1; m_ready = 1'b1;
        seen = 0; guard = 0;
        while (!seen && guard < 50) begin
            @(negedge clk);
            #1;
            seen = ap_done;
            guard++;
        end
        chk("b2b_first_done", DW'(seen), DW'(1));
        @(negedge clk);
        #1;
        chk("b2b_idle_cycle", DW'(ap_idle), DW'(1));
        @(negedge clk);
        ap_start = 1'b0;
        #1;
        chk("b2b_restart", DW'(ap_idle), '0);
        chk("b2b_issue", DW'(ce0), DW'(1));
        chk("b2b_addr", DW'(address0), DW'(4000));
        seen = 0; guard = 0;
        while (!seen && guard < 50) begin
            @(negedge clk);
            #1;
            seen = ap_done;
            if (seen) chk("b2b_second_err", DW'(ap_err), '0);
            guard++;
        end
        chk("b2b_second_done", DW'(seen), DW'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
